// File: rtl/data_mem_access_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_access_unit_pkg: funct3 codes, FSM states, store byte-enables  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package data_mem_access_unit_pkg;

  localparam logic [2:0] c_LB  = 3'b000;
  localparam logic [2:0] c_LH  = 3'b001;
  localparam logic [2:0] c_LW  = 3'b010;
  localparam logic [2:0] c_LBU = 3'b100;
  localparam logic [2:0] c_LHU = 3'b101;

  localparam logic [1:0] c_SB = 2'b00;
  localparam logic [1:0] c_SH = 2'b01;
  localparam logic [1:0] c_SW = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  function automatic logic [3:0] store_be(input logic [1:0] f3, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (f3)
      c_SB:    be = 4'b0001 << off;
      c_SH:    be = off[1] ? 4'b1100 : 4'b0011;
      c_SW:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_access_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_access_unit_if: req/ack word-wide data-memory port              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface data_mem_access_unit_if;
  logic        req;
  logic        we;
  logic [29:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport master (output req, we, addr, be, wdata, input rdata, ack);
  modport slave  (input req, we, addr, be, wdata, output rdata, ack);
endinterface
`default_nettype wire

// File: rtl/data_mem_access_unit_load_extender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_access_unit_load_extender: lane select and sign/zero extension  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_mem_access_unit_load_extender
  import data_mem_access_unit_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  offset_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = word_i[7:0];
    case (offset_i)
      2'd0:    w_byte = word_i[7:0];
      2'd1:    w_byte = word_i[15:8];
      2'd2:    w_byte = word_i[23:16];
      default: w_byte = word_i[31:24];
    endcase
    w_half = offset_i[1] ? word_i[31:16] : word_i[15:0];

    data_o = 32'd0;
    case (funct3_i)
      c_LB:    data_o = {{24{w_byte[7]}}, w_byte};
      c_LH:    data_o = {{16{w_half[15]}}, w_half};
      c_LW:    data_o = word_i;
      c_LBU:   data_o = {24'd0, w_byte};
      c_LHU:   data_o = {16'd0, w_half};
      default: data_o = 32'd0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_access_unit: MEM-stage load/store sequencer with stall + faults |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module data_mem_access_unit
  import data_mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  main_mem_read_i,
  input  logic [2:0]  main_mem_write_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        busywait_o,
  output logic        access_fault_o,
  data_mem_access_unit_if.master mem_if
);

  localparam int unsigned CW    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [CW-1:0] c_LIMIT = CW'(LIMIT);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           we_q, we_d;
  logic [31:0]    addr_q, addr_d;
  logic [2:0]     f3_q, f3_d;
  logic [3:0]     be_q, be_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [31:0]    rdata_q, rdata_d;

  logic           w_st_en, w_ld_en, w_bad;
  logic [1:0]     w_off, w_sf3;
  logic [2:0]     w_lf3;
  logic [31:0]    w_ext;

  assign w_st_en = main_mem_write_i[2];
  assign w_ld_en = main_mem_read_i[3];
  assign w_sf3   = main_mem_write_i[1:0];
  assign w_lf3   = main_mem_read_i[2:0];
  assign w_off   = address_i[1:0];

  // Store wins when both enables are set, so only its funct3 is checked then.
  always_comb begin
    w_bad = 1'b0;
    if (w_st_en) begin
      w_bad = (w_sf3 == 2'b11) || ((w_sf3 == c_SH) && w_off[0]) ||
              ((w_sf3 == c_SW) && (w_off != 2'b00));
    end else if (w_ld_en) begin
      w_bad = (w_lf3 == 3'b011) || (w_lf3 == 3'b110) || (w_lf3 == 3'b111) ||
              (((w_lf3 == c_LH) || (w_lf3 == c_LHU)) && w_off[0]) ||
              ((w_lf3 == c_LW) && (w_off != 2'b00));
    end
  end

  data_mem_access_unit_load_extender u_ext (
    .word_i   (rdata_q),
    .offset_i (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (w_ext)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    we_d           = we_q;
    addr_d         = addr_q;
    f3_d           = f3_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    rdata_d        = rdata_q;
    busywait_o     = 1'b0;
    access_fault_o = 1'b0;
    read_data_o    = 32'd0;
    mem_if.req     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_st_en || w_ld_en) begin
          // Outputs read as zero while reset is held, even with a request present.
          busywait_o = rst_n;
          if (w_bad) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
            we_d    = w_st_en;
            addr_d  = address_i;
            if (w_st_en) begin
              f3_d = {1'b0, w_sf3};
              be_d = store_be(w_sf3, w_off);
              case (w_sf3)
                c_SB:    wdata_d = {4{write_data_i[7:0]}};
                c_SH:    wdata_d = {2{write_data_i[15:0]}};
                default: wdata_d = write_data_i;
              endcase
            end else begin
              f3_d    = w_lf3;
              be_d    = 4'b1111;
              wdata_d = 32'd0;
            end
          end
        end
      end
      ST_ACCESS: begin
        mem_if.req = 1'b1;
        busywait_o = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        if (mem_if.ack) begin
          if (!we_q) rdata_d = mem_if.rdata;
          state_d = ST_DONE;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == c_LIMIT)) begin
          state_d = ST_FAULT;
        end
      end
      ST_DONE: begin
        read_data_o = we_q ? 32'd0 : w_ext;
        state_d     = ST_IDLE;
      end
      default: begin
        access_fault_o = 1'b1;
        state_d        = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      f3_q    <= 3'd0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_if.we    = we_q;
  assign mem_if.addr  = addr_q[31:2];
  assign mem_if.be    = be_q;
  assign mem_if.wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_access_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_data_mem_access_unit: directed load/store/fault/timeout/reset vectors |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_data_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  rd;
  logic [2:0]  wr;
  logic [31:0] addr, wd, read_data;
  logic        busy, flt;

  int n_checks = 0;
  int n_errors = 0;
  int total_req;

  logic        cap_we;
  logic [29:0] cap_addr;
  logic [3:0]  cap_be;
  logic [31:0] cap_wdata;
  logic [31:0] mem_word;

  int          b_n, r_n;
  logic [31:0] rdo;
  logic        fo;

  always #5 clk = ~clk;

  data_mem_access_unit_if bus ();

  data_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .main_mem_read_i  (rd),
    .main_mem_write_i (wr),
    .address_i        (addr),
    .write_data_i     (wd),
    .read_data_o      (read_data),
    .busywait_o       (busy),
    .access_fault_o   (flt),
    .mem_if           (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  // Runs one request from IDLE until BUSYWAIT drops; ack_at=0 means never acknowledge.
  task automatic do_access(input logic [3:0] r, input logic [2:0] w, input logic [31:0] a,
                           input logic [31:0] d, input int ack_at, input logic [31:0] rdat,
                           output int busy_n, output int req_n, output logic [31:0] rd_out,
                           output logic f_out);
    bit finished;
    finished = 1'b0;
    rd = r; wr = w; addr = a; wd = d;
    busy_n = 0; req_n = 0; rd_out = 32'd0; f_out = 1'b0;
    for (int c = 0; c < 40 && !finished; c++) begin
      #1;
      if (busy) busy_n++;
      if (bus.req) begin
        req_n++;
        total_req++;
        if (req_n == 1) begin
          cap_we = bus.we; cap_addr = bus.addr; cap_be = bus.be; cap_wdata = bus.wdata;
        end
        if (req_n == ack_at) begin
          bus.ack   = 1'b1;
          bus.rdata = rdat;
          if (bus.we) begin
            for (int i = 0; i < 4; i++)
              if (bus.be[i]) mem_word[8*i +: 8] = bus.wdata[8*i +: 8];
          end
        end
      end
      if (!busy) begin
        rd_out = read_data;
        f_out  = flt;
        finished = 1'b1;
      end else begin
        step();
        bus.ack = 1'b0;
      end
    end
    check_eq("access_terminates", {31'd0, finished}, 32'd1);
    rd = 4'd0; wr = 3'd0;
    step();
  endtask

  initial begin
    rst_n = 1'b0; rd = 4'd0; wr = 3'd0; addr = 32'd0; wd = 32'd0;
    bus.ack = 1'b0; bus.rdata = 32'd0; total_req = 0; mem_word = 32'd0;
    cap_we = 1'b0; cap_addr = 30'd0; cap_be = 4'd0; cap_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_fault", {31'd0, flt}, 32'd0);
    check_eq("rst_rdata", read_data, 32'd0);
    check_eq("rst_req",   {31'd0, bus.req}, 32'd0);
    check_eq("rst_we",    {31'd0, bus.we}, 32'd0);
    check_eq("rst_addr",  {2'd0, bus.addr}, 32'd0);
    check_eq("rst_be",    {28'd0, bus.be}, 32'd0);
    check_eq("rst_wdata", bus.wdata, 32'd0);
    rst_n = 1'b1;
    step();

    // LB at 0x1003, ack on third ACCESS cycle
    do_access(4'b1000, 3'b000, 32'h0000_1003, 32'd0, 3, 32'h80FF_1234, b_n, r_n, rdo, fo);
    check_eq("lb_busy_cycles", b_n, 4);
    check_eq("lb_req_cycles",  r_n, 3);
    check_eq("lb_data",        rdo, 32'hFFFF_FF80);
    check_eq("lb_fault",       {31'd0, fo}, 32'd0);
    check_eq("lb_be",          {28'd0, cap_be}, 32'hF);
    check_eq("lb_addr",        {2'd0, cap_addr}, 32'h400);
    check_eq("lb_we",          {31'd0, cap_we}, 32'd0);

    do_access(4'b1100, 3'b000, 32'h0000_1003, 32'd0, 3, 32'h80FF_1234, b_n, r_n, rdo, fo);
    check_eq("lbu_data", rdo, 32'h0000_0080);

    do_access(4'b1001, 3'b000, 32'h0000_1002, 32'd0, 1, 32'h80FF_1234, b_n, r_n, rdo, fo);
    check_eq("lh_busy_cycles", b_n, 2);
    check_eq("lh_data",        rdo, 32'hFFFF_80FF);

    do_access(4'b1101, 3'b000, 32'h0000_1000, 32'd0, 1, 32'h80FF_8234, b_n, r_n, rdo, fo);
    check_eq("lhu_data", rdo, 32'h0000_8234);

    // SH at 0x2002
    do_access(4'b0000, 3'b101, 32'h0000_2002, 32'hDEAD_BEEF, 2, 32'h1111_1111, b_n, r_n, rdo, fo);
    check_eq("sh_we",    {31'd0, cap_we}, 32'd1);
    check_eq("sh_be",    {28'd0, cap_be}, 32'hC);
    check_eq("sh_wdata", cap_wdata, 32'hBEEF_BEEF);
    check_eq("sh_addr",  {2'd0, cap_addr}, 32'h800);
    check_eq("sh_rdata", rdo, 32'd0);

    // SB and LW both requested: store wins
    do_access(4'b1010, 3'b100, 32'h0000_5001, 32'h1234_56A5, 1, 32'h2222_2222, b_n, r_n, rdo, fo);
    check_eq("prio_we",    {31'd0, cap_we}, 32'd1);
    check_eq("prio_be",    {28'd0, cap_be}, 32'h2);
    check_eq("prio_wdata", cap_wdata, 32'hA5A5_A5A5);
    check_eq("prio_addr",  {2'd0, cap_addr}, 32'h1400);

    // Misaligned LW at 0x3001
    do_access(4'b1010, 3'b000, 32'h0000_3001, 32'd0, 1, 32'd0, b_n, r_n, rdo, fo);
    check_eq("mis_busy_cycles", b_n, 1);
    check_eq("mis_req_cycles",  r_n, 0);
    check_eq("mis_fault",       {31'd0, fo}, 32'd1);
    check_eq("mis_rdata",       rdo, 32'd0);
    #1;
    check_eq("mis_fault_pulse", {31'd0, flt}, 32'd0);
    step();

    do_access(4'b1011, 3'b000, 32'h0000_0000, 32'd0, 1, 32'd0, b_n, r_n, rdo, fo);
    check_eq("ill_load_fault", {31'd0, fo}, 32'd1);
    check_eq("ill_load_req",   r_n, 0);

    do_access(4'b0000, 3'b111, 32'h0000_0000, 32'd0, 1, 32'd0, b_n, r_n, rdo, fo);
    check_eq("ill_store_fault", {31'd0, fo}, 32'd1);
    check_eq("ill_store_req",   r_n, 0);

    // Timeout after 4 ACCESS cycles, then a normal request
    do_access(4'b1010, 3'b000, 32'h0000_0040, 32'd0, 0, 32'd0, b_n, r_n, rdo, fo);
    check_eq("to_busy_cycles", b_n, 5);
    check_eq("to_req_cycles",  r_n, 4);
    check_eq("to_fault",       {31'd0, fo}, 32'd1);
    check_eq("to_rdata",       rdo, 32'd0);
    do_access(4'b1010, 3'b000, 32'h0000_0044, 32'd0, 1, 32'h55AA_55AA, b_n, r_n, rdo, fo);
    check_eq("after_to_data",  rdo, 32'h55AA_55AA);
    check_eq("after_to_fault", {31'd0, fo}, 32'd0);

    // Reset asserted mid-ACCESS
    rd = 4'b1010; addr = 32'h0000_0060;
    step();
    step();
    #1;
    check_eq("rst_mid_req_before", {31'd0, bus.req}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_req",  {31'd0, bus.req}, 32'd0);
    check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
    rd = 4'd0;
    step();
    rst_n = 1'b1;
    step();
    bus.ack = 1'b1; bus.rdata = 32'hFFFF_FFFF;
    #1;
    check_eq("late_ack_busy",  {31'd0, busy}, 32'd0);
    check_eq("late_ack_req",   {31'd0, bus.req}, 32'd0);
    check_eq("late_ack_rdata", read_data, 32'd0);
    step();
    bus.ack = 1'b0;
    #1;
    check_eq("late_ack_rdata_next", read_data, 32'd0);
    check_eq("late_ack_fault_next", {31'd0, flt}, 32'd0);
    step();

    // Back-to-back SW then LW at 0x10
    total_req = 0; mem_word = 32'd0;
    do_access(4'b0000, 3'b110, 32'h0000_0010, 32'hCAFE_F00D, 1, 32'd0, b_n, r_n, rdo, fo);
    check_eq("sw_busy_cycles", b_n, 2);
    check_eq("sw_req_cycles",  r_n, 1);
    check_eq("sw_mem",         mem_word, 32'hCAFE_F00D);
    do_access(4'b1010, 3'b000, 32'h0000_0010, 32'd0, 1, mem_word, b_n, r_n, rdo, fo);
    check_eq("lw_back_data", rdo, 32'hCAFE_F00D);
    check_eq("lw_req_cycles", r_n, 1);
    check_eq("b2b_total_req", total_req, 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
